// File: rtl/rv_step_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_check_pkg
//  Description : Shared types and constants for the Risc32 step checker.
//                state_t  - sequencer state encoding
//                KIND_*   - expected-table entry kinds
//  Revision    : 1.0  initial release
// ============================================================================
package rv_check_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        STEP  = 3'd2,
        READ  = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] KIND_REG  = 2'd0;
    localparam logic [1:0] KIND_MEM  = 2'd1;
    localparam logic [1:0] KIND_PCN  = 2'd2;
    localparam logic [1:0] KIND_SKIP = 2'd3;

    // True for the four states that make up one step of a run.
    function automatic logic is_busy_state(input state_t s);
        return (s == FETCH) || (s == STEP) || (s == READ) || (s == CMP);
    endfunction

endpackage : rv_check_pkg
`default_nettype wire

// File: rtl/rv_step_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv_step_checker_if
//  Description : Bundles the control, core, expected-table, debug and status
//                signals of the step checker.
//                master : checker side (drives step_en, exp_idx, dbg_*, status)
//                slave  : environment side (drives start/abort/num_steps,
//                         pc_next, exp_*, dbg_rdata)
//  Revision    : 1.0  initial release
// ============================================================================
interface rv_step_checker_if #(
    parameter int XLEN      = 32,
    parameter int STEPS_MAX = 32,
    parameter int ADDR_W    = 5
);
    localparam int IDX_W = $clog2(STEPS_MAX);

    // run control
    logic              start;
    logic              abort;
    logic [IDX_W:0]    num_steps;
    // core
    logic              step_en;
    logic [XLEN-1:0]   pc_next;
    // expected-result table
    logic [IDX_W-1:0]  exp_idx;
    logic [1:0]        exp_kind;
    logic [ADDR_W-1:0] exp_addr;
    logic [XLEN-1:0]   exp_value;
    // debug read port
    logic              dbg_sel;
    logic [ADDR_W-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_rdata;
    // status
    logic              busy;
    logic              done;
    logic              pass;
    logic [IDX_W:0]    fail_count;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [XLEN-1:0]   first_fail_got;

    modport master (
        input  start, abort, num_steps, pc_next,
        input  exp_kind, exp_addr, exp_value, dbg_rdata,
        output step_en, exp_idx, dbg_sel, dbg_addr,
        output busy, done, pass, fail_count, first_fail_idx, first_fail_got
    );

    modport slave (
        output start, abort, num_steps, pc_next,
        output exp_kind, exp_addr, exp_value, dbg_rdata,
        input  step_en, exp_idx, dbg_sel, dbg_addr,
        input  busy, done, pass, fail_count, first_fail_idx, first_fail_got
    );

endinterface : rv_step_checker_if
`default_nettype wire

// File: rtl/rv_step_checker.sv
`default_nettype none
// ============================================================================
//  Module      : rv_step_checker
//  Description : Steps the single-cycle Risc32 core one instruction at a time
//                via step_en, reads back a register / data-memory word / next
//                PC after each step and compares it against an external
//                expected-result table. Reports pass/fail counts and the first
//                failing step.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - rv_step_checker_if.master (control, core, table,
//                         debug read port, status)
//  Revision    : 1.0  initial release
// ============================================================================
module rv_step_checker
    import rv_check_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEPS_MAX = 32,
    parameter int ADDR_W    = 5
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rv_step_checker_if.master   bus
);

    localparam int IDX_W = $clog2(STEPS_MAX);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] STEPS_MAX_C = CNT_W'(STEPS_MAX);
    localparam logic [CNT_W-1:0] FAIL_SAT    = {CNT_W{1'b1}};

    state_t            state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [CNT_W-1:0]  nsteps_q, nsteps_d;
    logic [1:0]        kind_q,   kind_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [XLEN-1:0]   value_q,  value_d;
    logic [XLEN-1:0]   got_q,    got_d;
    logic [CNT_W-1:0]  fail_q,   fail_d;
    logic [IDX_W-1:0]  ffidx_q,  ffidx_d;
    logic [XLEN-1:0]   ffgot_q,  ffgot_d;

    logic [CNT_W-1:0]  w_eff_steps;
    logic [XLEN-1:0]   w_got;
    logic              w_mismatch;
    logic              w_last;

    // Requests beyond the table depth are clamped rather than rejected.
    assign w_eff_steps = (bus.num_steps > STEPS_MAX_C) ? STEPS_MAX_C : bus.num_steps;

    // PCN compares the next PC captured before the step; REG/MEM use the
    // debug read issued in READ, which arrives during CMP.
    assign w_got      = (kind_q == KIND_PCN) ? got_q : bus.dbg_rdata;
    assign w_mismatch = (kind_q != KIND_SKIP) && (w_got != value_q);
    assign w_last     = ((CNT_W'(idx_q) + CNT_W'(1)) == nsteps_q);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nsteps_d = nsteps_q;
        kind_d   = kind_q;
        addr_d   = addr_q;
        value_d  = value_q;
        got_d    = got_q;
        fail_d   = fail_q;
        ffidx_d  = ffidx_q;
        ffgot_d  = ffgot_q;

        if (bus.abort) begin
            // Counters are deliberately left untouched for inspection.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        nsteps_d = w_eff_steps;
                        idx_d    = '0;
                        fail_d   = '0;
                        ffidx_d  = '0;
                        ffgot_d  = '0;
                        state_d  = (w_eff_steps == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    kind_d  = bus.exp_kind;
                    addr_d  = bus.exp_addr;
                    value_d = bus.exp_value;
                    got_d   = (bus.exp_kind == KIND_PCN) ? bus.pc_next : '0;
                    state_d = STEP;
                end
                STEP: begin
                    state_d = READ;
                end
                READ: begin
                    state_d = CMP;
                end
                CMP: begin
                    if (w_mismatch) begin
                        if (fail_q != FAIL_SAT) begin
                            fail_d = fail_q + CNT_W'(1);
                        end
                        if (fail_q == '0) begin
                            ffidx_d = idx_q;
                            ffgot_d = w_got;
                        end
                    end
                    if (w_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            nsteps_q <= '0;
            kind_q   <= '0;
            addr_q   <= '0;
            value_q  <= '0;
            got_q    <= '0;
            fail_q   <= '0;
            ffidx_q  <= '0;
            ffgot_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nsteps_q <= nsteps_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            value_q  <= value_d;
            got_q    <= got_d;
            fail_q   <= fail_d;
            ffidx_q  <= ffidx_d;
            ffgot_q  <= ffgot_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state so an asynchronous reset
    // drops step_en without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign bus.step_en        = (state_q == STEP);
    assign bus.busy           = is_busy_state(state_q);
    assign bus.done           = (state_q == DONE);
    assign bus.pass           = (state_q == DONE) && (fail_q == '0);
    assign bus.fail_count     = fail_q;
    assign bus.first_fail_idx = ffidx_q;
    assign bus.first_fail_got = ffgot_q;
    assign bus.exp_idx        = idx_q;
    assign bus.dbg_sel        = (state_q == READ) && (kind_q == KIND_MEM);
    assign bus.dbg_addr       = (state_q == READ) ? addr_q : '0;

endmodule : rv_step_checker
`default_nettype wire

// File: tb/tb_rv_step_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_step_checker
//  Description : Directed self-checking bench for rv_step_checker. Contains a
//                tiny behavioural core (register file, data memory, PC) that
//                applies a scripted write on each step_en, plus an expected
//                table ROM driven from exp_idx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_step_checker;

    localparam int XLEN      = 32;
    localparam int STEPS_MAX = 32;
    localparam int ADDR_W    = 5;

    logic clk;
    logic rst_n;

    rv_step_checker_if #(.XLEN(XLEN), .STEPS_MAX(STEPS_MAX), .ADDR_W(ADDR_W)) bus ();

    rv_step_checker #(.XLEN(XLEN), .STEPS_MAX(STEPS_MAX), .ADDR_W(ADDR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected table ROM ----------------
    logic [1:0]  e_kind [32];
    logic [4:0]  e_addr [32];
    logic [31:0] e_val  [32];

    assign bus.exp_kind  = e_kind[bus.exp_idx];
    assign bus.exp_addr  = e_addr[bus.exp_idx];
    assign bus.exp_value = e_val[bus.exp_idx];

    // ---------------- behavioural core ----------------
    // p_kind: 0 = no write, 1 = register write, 2 = data-memory write
    logic [1:0]  p_kind [32];
    logic [4:0]  p_addr [32];
    logic [31:0] p_val  [32];
    logic [31:0] pc_init;
    logic        core_clr;

    logic [31:0] rf [32];
    logic [31:0] dm [32];
    logic [31:0] pc;
    logic [4:0]  sc;

    assign bus.pc_next = pc + 32'd4;

    always @(posedge clk) begin
        if (core_clr) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
                dm[i] <= 32'd0;
            end
            pc <= pc_init;
            sc <= 5'd0;
            bus.dbg_rdata <= 32'd0;
        end else begin
            if (bus.step_en) begin
                if (p_kind[sc] == 2'd1) rf[p_addr[sc]] <= p_val[sc];
                if (p_kind[sc] == 2'd2) dm[p_addr[sc]] <= p_val[sc];
                pc <= pc + 32'd4;
                sc <= sc + 5'd1;
            end
            bus.dbg_rdata <= bus.dbg_sel ? dm[bus.dbg_addr] : rf[bus.dbg_addr];
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- run bookkeeping ----------------
    int n_pulse;
    int pulse_cyc [4];
    int done_cyc;
    int sel_cnt;
    int sel_cyc;
    logic [4:0] sel_addr;

    task automatic set_e(input int i, input logic [1:0] k, input logic [4:0] a, input logic [31:0] v);
        e_kind[i] = k; e_addr[i] = a; e_val[i] = v;
    endtask

    task automatic set_p(input int i, input logic [1:0] k, input logic [4:0] a, input logic [31:0] v);
        p_kind[i] = k; p_addr[i] = a; p_val[i] = v;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 32; i++) begin
            set_e(i, 2'd3, 5'd0, 32'd0);
            set_p(i, 2'd0, 5'd0, 32'd0);
        end
        pc_init = 32'd0;
    endtask

    task automatic core_reset();
        core_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        core_clr = 1'b0;
    endtask

    // Starts a run; cycle c counts clock edges after the one that sampled start.
    task automatic run(input logic [5:0] n, input int abort_at, input int restart_at, input int maxc);
        bit finished = 0;
        n_pulse = 0; done_cyc = -1; sel_cnt = 0; sel_cyc = -1; sel_addr = '0;
        for (int i = 0; i < 4; i++) pulse_cyc[i] = -1;
        @(negedge clk);
        bus.num_steps = n;
        bus.start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (bus.step_en) begin
                if (n_pulse < 4) pulse_cyc[n_pulse] = c;
                n_pulse++;
            end
            if (bus.dbg_sel) begin
                sel_cnt++; sel_cyc = c; sel_addr = bus.dbg_addr;
            end
            if (bus.done) begin
                done_cyc = c; finished = 1; break;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                finished = 1; break;
            end
            if (c == restart_at) bus.start = 1'b1;
            if (c == abort_at)   bus.abort = 1'b1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (!finished) check_eq("run_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        core_clr = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_steps = '0;
        clear_tables();
        repeat (3) @(negedge clk);

        // ---- reset values ----
        check_eq("rst_step_en", 64'(bus.step_en), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_pass", 64'(bus.pass), 64'd0);
        check_eq("rst_fail_count", 64'(bus.fail_count), 64'd0);
        check_eq("rst_ff_idx", 64'(bus.first_fail_idx), 64'd0);
        check_eq("rst_ff_got", 64'(bus.first_fail_got), 64'd0);
        check_eq("rst_exp_idx", 64'(bus.exp_idx), 64'd0);
        check_eq("rst_dbg_sel", 64'(bus.dbg_sel), 64'd0);
        check_eq("rst_dbg_addr", 64'(bus.dbg_addr), 64'd0);
        rst_n = 1'b1;
        core_clr = 1'b0;

        // ---- known-good 3-step run, with an ignored start at cycle 5 ----
        clear_tables();
        set_e(0, 2'd0, 5'd3, 32'h1); set_p(0, 2'd1, 5'd3, 32'h1);
        set_e(1, 2'd0, 5'd1, 32'h2); set_p(1, 2'd1, 5'd1, 32'h2);
        set_e(2, 2'd0, 5'd2, 32'h3); set_p(2, 2'd1, 5'd2, 32'h3);
        core_reset();
        run(6'd3, -1, 5, 50);
        check_eq("good_pulses", 64'(n_pulse), 64'd3);
        check_eq("good_pulse0", 64'(pulse_cyc[0]), 64'd2);
        check_eq("good_pulse1", 64'(pulse_cyc[1]), 64'd6);
        check_eq("good_pulse2", 64'(pulse_cyc[2]), 64'd10);
        check_eq("good_done_cyc", 64'(done_cyc), 64'd13);
        check_eq("good_pass", 64'(bus.pass), 64'd1);
        check_eq("good_fail_count", 64'(bus.fail_count), 64'd0);
        check_eq("good_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_eq("good_done_held", 64'(bus.done), 64'd1);

        // ---- single mismatch at entry 1 ----
        clear_tables();
        set_e(0, 2'd0, 5'd3, 32'h1); set_p(0, 2'd1, 5'd3, 32'h1);
        set_e(1, 2'd0, 5'd1, 32'h2); set_p(1, 2'd1, 5'd1, 32'h5);
        set_e(2, 2'd0, 5'd2, 32'h3); set_p(2, 2'd1, 5'd2, 32'h3);
        core_reset();
        run(6'd3, -1, -1, 50);
        check_eq("mm_pulses", 64'(n_pulse), 64'd3);
        check_eq("mm_done_cyc", 64'(done_cyc), 64'd13);
        check_eq("mm_fail_count", 64'(bus.fail_count), 64'd1);
        check_eq("mm_ff_idx", 64'(bus.first_fail_idx), 64'd1);
        check_eq("mm_ff_got", 64'(bus.first_fail_got), 64'h5);
        check_eq("mm_pass", 64'(bus.pass), 64'd0);

        // ---- PCN and MEM ----
        clear_tables();
        pc_init = 32'h38;
        set_e(0, 2'd2, 5'd0, 32'h3c);
        set_e(1, 2'd1, 5'd1, 32'h3);  set_p(1, 2'd2, 5'd1, 32'h3);
        set_e(2, 2'd0, 5'd4, 32'h7);  set_p(2, 2'd1, 5'd4, 32'h7);
        core_reset();
        run(6'd3, -1, -1, 50);
        check_eq("pm_done_cyc", 64'(done_cyc), 64'd13);
        check_eq("pm_pass", 64'(bus.pass), 64'd1);
        check_eq("pm_fail_count", 64'(bus.fail_count), 64'd0);
        check_eq("pm_sel_cnt", 64'(sel_cnt), 64'd1);
        check_eq("pm_sel_cyc", 64'(sel_cyc), 64'd7);
        check_eq("pm_sel_addr", 64'(sel_addr), 64'd1);

        // ---- PCN mismatch records the sampled next PC ----
        clear_tables();
        pc_init = 32'h38;
        set_e(0, 2'd2, 5'd0, 32'h40);
        core_reset();
        run(6'd1, -1, -1, 20);
        check_eq("pcn_bad_done_cyc", 64'(done_cyc), 64'd5);
        check_eq("pcn_bad_fail", 64'(bus.fail_count), 64'd1);
        check_eq("pcn_bad_got", 64'(bus.first_fail_got), 64'h3c);

        // ---- num_steps = 63 saturates to 32 ----
        clear_tables();
        core_reset();
        run(6'd63, -1, -1, 200);
        check_eq("sat_pulses", 64'(n_pulse), 64'd32);
        check_eq("sat_done_cyc", 64'(done_cyc), 64'd129);
        check_eq("sat_pass", 64'(bus.pass), 64'd1);
        check_eq("sat_exp_idx", 64'(bus.exp_idx), 64'd31);

        // ---- abort at step 2, counters retained ----
        clear_tables();
        set_e(0, 2'd0, 5'd1, 32'h9); set_p(0, 2'd1, 5'd1, 32'h2);
        set_e(1, 2'd0, 5'd2, 32'h3); set_p(1, 2'd1, 5'd2, 32'h3);
        set_e(2, 2'd0, 5'd3, 32'h4); set_p(2, 2'd1, 5'd3, 32'h4);
        core_reset();
        run(6'd3, 9, -1, 50);
        check_eq("ab_pulses", 64'(n_pulse), 64'd2);
        check_eq("ab_done", 64'(bus.done), 64'd0);
        check_eq("ab_busy", 64'(bus.busy), 64'd0);
        check_eq("ab_step_en", 64'(bus.step_en), 64'd0);
        check_eq("ab_fail_count", 64'(bus.fail_count), 64'd1);
        check_eq("ab_ff_idx", 64'(bus.first_fail_idx), 64'd0);
        check_eq("ab_ff_got", 64'(bus.first_fail_got), 64'h2);

        // ---- new start with num_steps = 0 clears counters ----
        run(6'd0, -1, -1, 10);
        check_eq("zero_done_cyc", 64'(done_cyc), 64'd1);
        check_eq("zero_pulses", 64'(n_pulse), 64'd0);
        check_eq("zero_pass", 64'(bus.pass), 64'd1);
        check_eq("zero_fail_count", 64'(bus.fail_count), 64'd0);
        check_eq("zero_ff_got", 64'(bus.first_fail_got), 64'd0);

        // ---- reset dropped mid-STEP ----
        clear_tables();
        core_reset();
        @(negedge clk);
        bus.num_steps = 6'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            int waited = 0;
            while (!bus.step_en && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check_eq("rs_saw_step", 64'(bus.step_en), 64'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check_eq("rs_step_en", 64'(bus.step_en), 64'd0);
        check_eq("rs_busy", 64'(bus.busy), 64'd0);
        check_eq("rs_done", 64'(bus.done), 64'd0);
        check_eq("rs_exp_idx", 64'(bus.exp_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rs_idle_busy", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rv_step_checker
`default_nettype wire
